dpd_lut_arbiter: RTL
====================

DPD_LUT_ARBITER -- requirements
Module: dpd_lut_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 10, LUT address width; DATA_WIDTH, default 32, LUT entry width; TAG_DEPTH, default 4, maximum outstanding reads (power of 2, minimum 2).
REQ-002 SHALL have ports: data_clk  in  1  sole clock; data_rstn  in  1  reset, asynchronous active-low.
REQ-003 SHALL have ports for requester n (n = 0 host, n = 1 loader): rn_valid in 1; rn_ready out 1; rn_we in 1 (1 = write); rn_addr in ADDR_WIDTH; rn_wdata in DATA_WIDTH; rn_rvalid out 1; rn_rdata out DATA_WIDTH.
REQ-004 SHALL have actuator-side ports: enc out 1; wec out 1; addrc out ADDR_WIDTH; dinc out DATA_WIDTH; doutc in DATA_WIDTH; validc in 1; lutIdc out 64.
REQ-005 SHALL have control/status ports: cfg_lutIdc in 64 (staged LUT selection); cfg_commit in 1 (pulse); commit_busy out 1; commit_done out 1 (pulse); err_spurious out 1 (sticky); err_clr in 1.

Function
REQ-006 SHALL transfer a request from requester n on any cycle where rn_valid and rn_ready are both 1.
REQ-007 SHALL drive rn_ready combinationally: at most one requester ready per cycle, and none while commit_busy is 1.
REQ-008 SHALL arbitrate round-robin: on contention, grant the requester not granted most recently; the pointer updates only on a transfer.
REQ-009 SHALL grant a read only when the tag FIFO is not full; a blocked read SHALL NOT block a write from the other requester.
REQ-010 SHALL register a granted request onto enc=1, wec=rn_we, addrc, dinc (wdata for writes, 0 for reads) one cycle after the transfer; enc SHALL be 0 on idle cycles with addrc/dinc=0.
REQ-011 SHALL push the requester ID of each granted read into a TAG_DEPTH-entry tag FIFO in the same cycle as the transfer.
REQ-012 On validc=1, SHALL pop the tag FIFO and pulse rn_rvalid for one cycle, with rn_rdata=doutc registered (1-cycle latency), for the popped ID only.
REQ-013 On validc=1 with the tag FIFO empty, SHALL set err_spurious, discard the data and produce no rvalid.
REQ-014 Simultaneous tag push and pop SHALL keep the occupancy count unchanged, including when the FIFO is full.
REQ-015 The commit FSM SHALL have states IDLE, DRAIN and APPLY.
REQ-016 IDLE->DRAIN on cfg_commit; cfg_lutIdc SHALL be captured in that cycle; commit_busy=1 in DRAIN and APPLY.
REQ-017 DRAIN->APPLY when the tag FIFO is empty and no enc is pending in the output register.
REQ-018 APPLY SHALL load lutIdc from the captured value, pulse commit_done, and return to IDLE next cycle.
REQ-019 cfg_commit asserted outside IDLE SHALL be ignored.
REQ-020 err_clr SHALL clear err_spurious; if err_clr and a new spurious validc occur in the same cycle, set SHALL win.

Reset
REQ-021 On data_rstn=0, all outputs SHALL be 0, the FSM SHALL be IDLE, the tag FIFO empty, the RR pointer favouring requester 0, and lutIdc=0.
REQ-022 Reset asserted mid-operation SHALL discard outstanding tags; validc after reset with no tags SHALL set err_spurious.

Configuration
REQ-023 With DPD_LUT_ARB_STATS_EN defined: add outputs stat_wr_cnt and stat_rd_cnt (16 bits each, saturating counters of granted writes/reads across both requesters, cleared by err_clr or reset).
REQ-024 Without DPD_LUT_ARB_STATS_EN: these ports SHALL still exist, tied to 0, with no counter logic.

Structure
REQ-025 The shared package SHALL hold the FSM state encoding, the requester-ID constants (REQ_HOST=0, REQ_LOADER=1) and the default parameter constants.
REQ-026 The tag FIFO SHALL be one sub-module, dpd_lut_tag_fifo (synchronous, count-based full/empty).

Verification
REQ-027 Host writes addr 0x005 with data 0xDEADBEEF -> next cycle enc=1, wec=1, addrc=0x005, dinc=0xDEADBEEF; one cycle later enc=0.
REQ-028 Both requesters hold valid for 4 cycles -> grants alternate 0,1,0,1.
REQ-029 Loader issues 4 reads with validc withheld (TAG_DEPTH=4); fifth loader read -> r1_ready=0 while a host write is still granted; returning validc data 0x11..0x44 -> r1_rvalid x4, in order.
REQ-030 Interleaved reads host,loader,host; validc data A,B,C -> r0 gets A and C, r1 gets B, each with 1-cycle latency.
REQ-031 cfg_commit with 2 reads outstanding, cfg_lutIdc=0x0123456789ABCDEF -> ready=0 during DRAIN; after the 2nd validc, APPLY, lutIdc=0x0123456789ABCDEF, single commit_done pulse.
REQ-032 validc with no outstanding reads -> err_spurious=1 and no rvalid; err_clr -> 0; with DPD_LUT_ARB_STATS_EN, 70000 writes -> stat_wr_cnt=0xFFFF.

Source files
------------

// File: rtl/dpd_lut_arbiter_pkg.sv
// Shared definitions for the DPD LUT arbiter slice.
// Holds the commit FSM state encoding, the requester-ID constants and the
// default parameter values used by dpd_lut_arbiter and dpd_lut_tag_fifo.
package dpd_lut_arbiter_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_TAG_DEPTH  = 4;

    localparam logic REQ_HOST   = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_APPLY = 2'd2
    } commit_state_e;

endpackage

// File: rtl/dpd_lut_tag_fifo.sv
// Tag FIFO recording which requester owns each outstanding LUT read.
// Synchronous, count-based full/empty; DEPTH must be a power of 2 (>= 2).
// Ports:
//   data_clk, data_rstn : clock, asynchronous active-low reset
//   push, push_id       : enqueue a requester ID
//   pop                 : dequeue (ignored while empty)
//   pop_id              : ID at the head of the FIFO
//   full, empty         : occupancy status
module dpd_lut_tag_fifo
    import dpd_lut_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_TAG_DEPTH
) (
    input  logic data_clk,
    input  logic data_rstn,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic pop_id,
    output logic full,
    output logic empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_id  = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the head slot, so a push is accepted even when full.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge data_clk or negedge data_rstn) begin
        if (!data_rstn) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dpd_lut_arbiter.sv
// Two-requester round-robin arbiter in front of a DPD actuator LUT port.
// Requester 0 = host, requester 1 = loader. Reads are tagged so the returning
// doutc/validc data is routed back to the issuing requester in order. A commit
// FSM drains outstanding traffic before switching the active LUT selection.
// Optional feature macro: DPD_LUT_ARB_STATS_EN (saturating write/read grant counters;
// when undefined the stat ports read as 0).
// Ports:
//   data_clk, data_rstn           : clock, asynchronous active-low reset
//   rN_valid/ready/we/addr/wdata  : request channel of requester N
//   rN_rvalid/rdata               : read return of requester N
//   enc/wec/addrc/dinc            : registered LUT access to the actuator
//   doutc/validc                  : read data return from the actuator
//   lutIdc                        : active LUT selection
//   cfg_lutIdc/cfg_commit         : staged LUT selection and commit pulse
//   commit_busy/commit_done       : commit in progress / completion pulse
//   err_spurious/err_clr          : sticky untagged-return error and its clear
//   stat_wr_cnt/stat_rd_cnt       : granted write/read counters
module dpd_lut_arbiter
    import dpd_lut_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned TAG_DEPTH  = DEF_TAG_DEPTH
) (
    input  logic                  data_clk,
    input  logic                  data_rstn,

    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,

    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,

    output logic                  enc,
    output logic                  wec,
    output logic [ADDR_WIDTH-1:0] addrc,
    output logic [DATA_WIDTH-1:0] dinc,
    input  logic [DATA_WIDTH-1:0] doutc,
    input  logic                  validc,
    output logic [63:0]           lutIdc,

    input  logic [63:0]           cfg_lutIdc,
    input  logic                  cfg_commit,
    output logic                  commit_busy,
    output logic                  commit_done,
    output logic                  err_spurious,
    input  logic                  err_clr,

    output logic [15:0]           stat_wr_cnt,
    output logic [15:0]           stat_rd_cnt
);

    commit_state_e         state;
    commit_state_e         state_nxt;
    logic                  busy;
    logic                  tag_full;
    logic                  tag_empty;
    logic                  tag_pop_id;
    logic                  elig0;
    logic                  elig1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rr_last;
    logic                  xfer;
    logic                  xfer_we;
    logic [ADDR_WIDTH-1:0] xfer_addr;
    logic [DATA_WIDTH-1:0] xfer_wdata;
    logic                  rd_hit;
    logic [63:0]           lut_stage;

    assign busy        = (state != ST_IDLE);
    assign commit_busy = busy;

    // data_rstn gating keeps the combinational readies at 0 during reset.
    assign elig0 = r0_valid & (r0_we | ~tag_full) & ~busy & data_rstn;
    assign elig1 = r1_valid & (r1_we | ~tag_full) & ~busy & data_rstn;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (elig0 && elig1) begin
            if (rr_last == REQ_HOST) gnt1 = 1'b1;
            else                     gnt0 = 1'b1;
        end else begin
            gnt0 = elig0;
            gnt1 = elig1;
        end
    end

    assign r0_ready   = gnt0;
    assign r1_ready   = gnt1;
    assign xfer       = gnt0 | gnt1;
    assign xfer_we    = gnt1 ? r1_we    : r0_we;
    assign xfer_addr  = gnt1 ? r1_addr  : r0_addr;
    assign xfer_wdata = gnt1 ? r1_wdata : r0_wdata;
    assign rd_hit     = validc & ~tag_empty;

    dpd_lut_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .data_clk  (data_clk),
        .data_rstn (data_rstn),
        .push      (xfer & ~xfer_we),
        .push_id   (gnt1),
        .pop       (validc),
        .pop_id    (tag_pop_id),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    // Actuator request register and round-robin pointer.
    always_ff @(posedge data_clk or negedge data_rstn) begin
        if (!data_rstn) begin
            enc     <= 1'b0;
            wec     <= 1'b0;
            addrc   <= '0;
            dinc    <= '0;
            rr_last <= REQ_LOADER;
        end else begin
            enc   <= xfer;
            wec   <= xfer & xfer_we;
            addrc <= xfer ? xfer_addr : '0;
            dinc  <= (xfer && xfer_we) ? xfer_wdata : '0;
            if (xfer) rr_last <= gnt1;
        end
    end

    // Read return routing and spurious-return error.
    always_ff @(posedge data_clk or negedge data_rstn) begin
        if (!data_rstn) begin
            r0_rvalid    <= 1'b0;
            r0_rdata     <= '0;
            r1_rvalid    <= 1'b0;
            r1_rdata     <= '0;
            err_spurious <= 1'b0;
        end else begin
            r0_rvalid <= rd_hit & (tag_pop_id == REQ_HOST);
            r1_rvalid <= rd_hit & (tag_pop_id == REQ_LOADER);
            if (rd_hit && tag_pop_id == REQ_HOST)   r0_rdata <= doutc;
            if (rd_hit && tag_pop_id == REQ_LOADER) r1_rdata <= doutc;
            if (validc && tag_empty) err_spurious <= 1'b1;
            else if (err_clr)        err_spurious <= 1'b0;
        end
    end

    // Commit FSM state register; lutIdc is loaded on entry to APPLY so it is
    // already valid in the cycle commit_done pulses.
    always_ff @(posedge data_clk or negedge data_rstn) begin
        if (!data_rstn) begin
            state     <= ST_IDLE;
            lut_stage <= '0;
            lutIdc    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && cfg_commit) lut_stage <= cfg_lutIdc;
            if (state == ST_DRAIN && state_nxt == ST_APPLY) lutIdc <= lut_stage;
        end
    end

    always_comb begin
        state_nxt   = state;
        commit_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_commit) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (tag_empty && !enc) state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                commit_done = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef DPD_LUT_ARB_STATS_EN
    always_ff @(posedge data_clk or negedge data_rstn) begin
        if (!data_rstn) begin
            stat_wr_cnt <= '0;
            stat_rd_cnt <= '0;
        end else if (err_clr) begin
            stat_wr_cnt <= '0;
            stat_rd_cnt <= '0;
        end else begin
            if (xfer && xfer_we && stat_wr_cnt != '1)
                stat_wr_cnt <= stat_wr_cnt + 16'd1;
            if (xfer && !xfer_we && stat_rd_cnt != '1)
                stat_rd_cnt <= stat_rd_cnt + 16'd1;
        end
    end
`else
    assign stat_wr_cnt = '0;
    assign stat_rd_cnt = '0;
`endif

endmodule
